key_sw_debounce: RTL and testbench

Input conditioning stage between the board's raw pushbutton/slide-switch pins and the Nios II SoC's PIO inputs (`key1_export`, `sw_export`). It synchronizes KEY[1] and SW[7:0] into the 50 MHz domain and debounces each channel independently. It then presents clean levels, single-cycle edge pulses and a sticky key-press event flag that software clears. The top level wires `sw_out` to the switch PIO and `key_event` to the KEY1 PIO in place of the raw pins.

---
 rtl/key_sw_pkg.sv | 19 +
 rtl/debounce_chan.sv | 97 +++++++++
 rtl/key_sw_debounce.sv | 89 ++++++++
 tb/tb_key_sw_debounce.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/key_sw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_sw_pkg                                                                 |
// | Shared constants and per-channel debounce state type for key_sw_debounce.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package key_sw_pkg;

  localparam int CLK_HZ                  = 50_000_000;
  localparam int DEBOUNCE_MS             = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

  typedef enum logic [0:0] {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } deb_state_t;

endpackage
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | debounce_chan                                                              |
// | One channel: 2-flop synchronizer plus debounce counter and stable level.   |
// | KEY_SW_DEBOUNCE_EN compiles in the counter; otherwise stable tracks sync.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module debounce_chan
  import key_sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_stable
);

  logic [1:0] r_sync;
  logic       r_stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_raw};
    end
  end

`ifdef KEY_SW_DEBOUNCE_EN
  localparam int              CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  deb_state_t       r_state;
  deb_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_stable_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= STABLE;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_stable <= w_stable_nxt;
    end
  end

  // A bounce back to the stable level abandons the count; acceptance
  // needs DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_stable_nxt = r_stable;
    case (r_state)
      STABLE: begin
        w_cnt_nxt = '0;
        if (r_sync[1] != r_stable) begin
          w_state_nxt = PENDING;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      PENDING: begin
        if (r_sync[1] == r_stable) begin
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_CNT_MAX) begin
          w_state_nxt  = STABLE;
          w_cnt_nxt    = '0;
          w_stable_nxt = r_sync[1];
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= 1'b0;
    end else begin
      r_stable <= r_sync[1];
    end
  end
`endif

  assign o_stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/key_sw_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_sw_debounce                                                            |
// | Conditions KEY[1] and SW[N_SW-1:0]: levels, edge pulses, sticky key event. |
// | Debounce counters are present only when KEY_SW_DEBOUNCE_EN is defined.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module key_sw_debounce
  import key_sw_pkg::*;
#(
  parameter int N_SW            = 8,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic            clk_clk,
  input  logic            reset_reset_n,
  input  logic            key_n_in,
  input  logic [N_SW-1:0] sw_in,
  input  logic            key_event_clr,
  output logic            key_level,
  output logic            key_press_pulse,
  output logic            key_event,
  output logic [N_SW-1:0] sw_out,
  output logic            sw_change_pulse
);

  logic            w_key_raw;
  logic            w_key_stable;
  logic            w_key_rise;
  logic [N_SW-1:0] w_sw_stable;
  logic            r_key_stable_d;
  logic [N_SW-1:0] r_sw_stable_d;
  logic            r_key_press_pulse;
  logic            r_sw_change_pulse;
  logic            r_key_event;

  // KEY[1] is active-low on the board; invert so 1 means pressed.
  assign w_key_raw = ~key_n_in;

  debounce_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .i_raw   (w_key_raw),
    .o_stable(w_key_stable)
  );

  for (genvar gi = 0; gi < N_SW; gi++) begin : g_sw
    debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw (
      .clk     (clk_clk),
      .rst_n   (reset_reset_n),
      .i_raw   (sw_in[gi]),
      .o_stable(w_sw_stable[gi])
    );
  end

  assign w_key_rise = w_key_stable & ~r_key_stable_d;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_key_stable_d    <= 1'b0;
      r_sw_stable_d     <= '0;
      r_key_press_pulse <= 1'b0;
      r_sw_change_pulse <= 1'b0;
      r_key_event       <= 1'b0;
    end else begin
      r_key_stable_d    <= w_key_stable;
      r_sw_stable_d     <= w_sw_stable;
      r_key_press_pulse <= w_key_rise;
      r_sw_change_pulse <= |(w_sw_stable ^ r_sw_stable_d);
      // A new press beats a simultaneous software clear.
      if (w_key_rise) begin
        r_key_event <= 1'b1;
      end else if (key_event_clr) begin
        r_key_event <= 1'b0;
      end
    end
  end

  assign key_level       = w_key_stable;
  assign sw_out          = w_sw_stable;
  assign key_press_pulse = r_key_press_pulse;
  assign sw_change_pulse = r_sw_change_pulse;
  assign key_event       = r_key_event;

endmodule
`default_nettype wire

// File: tb/tb_key_sw_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_key_sw_debounce                                                         |
// | Scoreboard bench: window-based reference model vs. key_sw_debounce.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_key_sw_debounce;

  localparam int N_SW = 8;
  localparam int DEB  = 16;
`ifdef KEY_SW_DEBOUNCE_EN
  localparam int D_EFF = DEB;
`else
  localparam int D_EFF = 1;
`endif

  logic            clk_clk       = 1'b1;
  logic            reset_reset_n = 1'b1;
  logic            key_n_in      = 1'b1;
  logic [N_SW-1:0] sw_in         = '0;
  logic            key_event_clr = 1'b0;
  logic            key_level;
  logic            key_press_pulse;
  logic            key_event;
  logic [N_SW-1:0] sw_out;
  logic            sw_change_pulse;

  always #5 clk_clk = ~clk_clk;

  key_sw_debounce #(
    .N_SW           (N_SW),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk_clk        (clk_clk),
    .reset_reset_n  (reset_reset_n),
    .key_n_in       (key_n_in),
    .sw_in          (sw_in),
    .key_event_clr  (key_event_clr),
    .key_level      (key_level),
    .key_press_pulse(key_press_pulse),
    .key_event      (key_event),
    .sw_out         (sw_out),
    .sw_change_pulse(sw_change_pulse)
  );

  typedef struct packed {
    logic            key_level;
    logic            key_press_pulse;
    logic            key_event;
    logic [N_SW-1:0] sw_out;
    logic            sw_change_pulse;
  } resp_t;

  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  // Reference model: raw samples per edge, newest at the back; bit N_SW is the key.
  logic [N_SW:0]   hist[$];
  logic            m_key, m_key_d, m_pulse, m_kev, m_swp;
  logic [N_SW-1:0] m_sw, m_sw_d;

  task automatic model_clear();
    hist.delete();
    for (int i = 0; i < D_EFF + 1; i++) hist.push_back('0);
    m_key = 1'b0; m_key_d = 1'b0; m_pulse = 1'b0; m_kev = 1'b0; m_swp = 1'b0;
    m_sw  = '0;   m_sw_d  = '0;
  endtask

  function automatic resp_t model_resp();
    resp_t r;
    r.key_level       = m_key;
    r.key_press_pulse = m_pulse;
    r.key_event       = m_kev;
    r.sw_out          = m_sw;
    r.sw_change_pulse = m_swp;
    return r;
  endfunction

  // A channel flips when the last D_EFF synchronized samples (raw delayed
  // two edges) all disagree with its current level.
  always @(posedge clk_clk) begin : model
    logic [N_SW:0] cur_stab, nxt_stab;
    logic          all_diff, p_new, s_new;
    if (!reset_reset_n) begin
      model_clear();
    end else begin
      hist.push_back({~key_n_in, sw_in});
      cur_stab = {m_key, m_sw};
      nxt_stab = cur_stab;
      for (int b = 0; b <= N_SW; b++) begin
        all_diff = 1'b1;
        for (int i = 0; i < D_EFF; i++)
          if (hist[hist.size() - 3 - i][b] == cur_stab[b]) all_diff = 1'b0;
        if (all_diff) nxt_stab[b] = ~cur_stab[b];
      end
      void'(hist.pop_front());
      p_new = m_key & ~m_key_d;
      s_new = (m_sw != m_sw_d);
      if (p_new) m_kev = 1'b1;
      else if (key_event_clr) m_kev = 1'b0;
      m_pulse = p_new;
      m_swp   = s_new;
      m_key_d = m_key;
      m_sw_d  = m_sw;
      {m_key, m_sw} = nxt_stab;
    end
    exp_q.push_back(model_resp());
  end

  // Asynchronous reset: outputs must already be zero by the next sample point.
  always @(negedge reset_reset_n) begin
    exp_q.delete();
    model_clear();
    exp_q.push_back(model_resp());
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk_clk) begin : monitor
    resp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("key_level",       32'(key_level),       32'(e.key_level));
      check("key_press_pulse", 32'(key_press_pulse), 32'(e.key_press_pulse));
      check("key_event",       32'(key_event),       32'(e.key_event));
      check("sw_out",          32'(sw_out),          32'(e.sw_out));
      check("sw_change_pulse", 32'(sw_change_pulse), 32'(e.sw_change_pulse));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  initial begin
    #1;
    reset_reset_n = 1'b0;
    key_n_in      = 1'b0;
    sw_in         = 8'hFF;
    step(3);
    reset_reset_n = 1'b1;   // key held through reset
    step(40);
    key_n_in = 1'b1; sw_in = 8'h00; step(40);

    key_n_in = 1'b0; step(40);  // clean press
    key_n_in = 1'b1; step(40);  // release

    key_n_in = 1'b0; step(10);  // bounce
    key_n_in = 1'b1; step(3);
    key_n_in = 1'b0; step(40);
    key_n_in = 1'b1; step(40);

    sw_in = 8'hA5; step(40);
    sw_in = 8'hA4; step(40);

    key_event_clr = 1'b1; step(1); key_event_clr = 1'b0; step(5);

    // Clear lands on the same edge the press pulse is set.
    key_n_in = 1'b0; step(2 + D_EFF);
    key_event_clr = 1'b1; step(1); key_event_clr = 1'b0; step(40);
    key_n_in = 1'b1; step(40);

    key_n_in = 1'b0; step(12);  // reset mid-count
    reset_reset_n = 1'b0; step(2);
    reset_reset_n = 1'b1; step(40);

    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 2) == 0) key_n_in = ~key_n_in;
      if ($urandom_range(0, 2) == 0) sw_in = sw_in ^ N_SW'($urandom);
      key_event_clr = ($urandom_range(0, 3) == 0);
      step(1);
      key_event_clr = 1'b0;
      step($urandom_range(0, 24));
    end
    step(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
